// File: rtl/lbp_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle for the LBP window sequencer.
// master = stream source and window sink side; slave = the sequencer itself.
interface lbp_window_ctrl_if #(
   parameter int PIX_W = 8
);
   logic [PIX_W-1:0]   pix_in;
   logic               pix_valid;
   logic               pix_ready;
   logic [9*PIX_W-1:0] win_out;
   logic               win_valid;
   logic               win_ready;

   modport master (
      output pix_in, pix_valid, win_ready,
      input  pix_ready, win_out, win_valid
   );

   modport slave (
      input  pix_in, pix_valid, win_ready,
      output pix_ready, win_out, win_valid
   );
endinterface

// File: rtl/lbp_window_ctrl.sv
// Raster-stream 3x3 window sequencer feeding the LBP core: two line buffers, shift window, one output stage.
// Optional macro LBP_WIN_CNT_EN adds win_cnt, a per-frame count of handed-off windows.
module lbp_window_ctrl #(
   parameter int PIX_W = 8,
   parameter int IMG_W = 64,
   parameter int IMG_H = 48
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_clr,
   lbp_window_ctrl_if.slave   bus,
`ifdef LBP_WIN_CNT_EN
   output logic [31:0]        win_cnt,
`endif
   output logic               frame_done,
   output logic               busy
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, FILL, RUN} stateT;

   stateT              state;
   logic [CW-1:0]      col;
   logic [RW-1:0]      row;
   logic               accept;
   logic               lastPixel;
   logic               emit;
   logic               winValid;
   logic [9*PIX_W-1:0] winOut;
   logic [9*PIX_W-1:0] winPacked;
   logic [PIX_W-1:0]   lb0 [IMG_W];
   logic [PIX_W-1:0]   lb1 [IMG_W];
   logic [PIX_W-1:0]   win [9];
   logic [PIX_W-1:0]   winNext [9];

   // A single output register: new pixels may enter only if that register is free or draining now.
   assign bus.pix_ready = (~winValid | bus.win_ready) & ~frame_clr;
   assign accept        = bus.pix_valid & bus.pix_ready;
   assign lastPixel     = (row == LAST_ROW) && (col == LAST_COL);
   assign emit          = (row >= RW'(2)) && (col >= CW'(2));
   assign bus.win_out   = winOut;
   assign bus.win_valid = winValid;
   assign busy          = (state != IDLE);

   // Window after the shift: slots 0..2 top row, 3..5 middle, 6..8 bottom; new column enters on the right.
   always_comb begin
      winNext[0] = win[1];
      winNext[1] = win[2];
      winNext[2] = lb1[col];
      winNext[3] = win[4];
      winNext[4] = win[5];
      winNext[5] = lb0[col];
      winNext[6] = win[7];
      winNext[7] = win[8];
      winNext[8] = bus.pix_in;
      winPacked  = '0;
      for (int i = 0; i < 9; i++) begin
         winPacked[i*PIX_W +: PIX_W] = winNext[i];
      end
   end

   // Line buffers carry no reset: every entry is rewritten before any window can use it.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[col] <= lb0[col];
         lb0[col] <= bus.pix_in;
      end
   end

   // Frame position, FSM, shift window and the output stage; frame_clr overrides any accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         winValid   <= 1'b0;
         winOut     <= '0;
         frame_done <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            win[i] <= '0;
         end
      end else begin
         frame_done <= 1'b0;
         if (frame_clr) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            winValid <= 1'b0;
         end else begin
            if (winValid && bus.win_ready) begin
               winValid <= 1'b0;
            end
            if (accept) begin
               for (int i = 0; i < 9; i++) begin
                  win[i] <= winNext[i];
               end
               if (emit) begin
                  winValid <= 1'b1;
                  winOut   <= winPacked;
               end
               if (col == LAST_COL) begin
                  col <= '0;
                  row <= (row == LAST_ROW) ? '0 : row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
               case (state)
                  IDLE: state <= FILL;
                  FILL: if (row == RW'(2) && col == '0) state <= RUN;
                  RUN:  if (lastPixel) state <= IDLE;
                  default: state <= IDLE;
               endcase
               if (lastPixel) begin
                  frame_done <= 1'b1;
               end
            end
         end
      end
   end

`ifdef LBP_WIN_CNT_EN
   logic clearPending;

   // Clearing one cycle after frame_done lets the frame's final handoff show in the count first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt      <= '0;
         clearPending <= 1'b0;
      end else begin
         clearPending <= frame_done & ~frame_clr;
         if (frame_clr) begin
            win_cnt <= '0;
         end else if (clearPending) begin
            win_cnt <= (winValid && bus.win_ready) ? 32'd1 : 32'd0;
         end else if (winValid && bus.win_ready && win_cnt != '1) begin
            win_cnt <= win_cnt + 1'b1;
         end
      end
   end
`endif

endmodule
